zircon_avalon_ps2_keyboard_rx_fifo: RTL

//  Second-generation PS/2 keyboard receiver for the Avalon keyboard IP.

---
 rtl/zircon_ps2_pkg.sv | 23 ++
 rtl/zircon_ps2_sync_fifo.sv | 55 +++++
 rtl/zircon_avalon_ps2_keyboard_rx_fifo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/zircon_ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: prefix codes, event word layout
// and the deserialiser state encoding.
package zircon_ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int EV_EXT   = 9;
    localparam int EV_BRK   = 8;
    localparam int EV_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    // Frame is {stop, parity, data[7:0], start}, start at bit 0.
    function automatic logic frame_ok(input logic [10:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/zircon_ps2_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an exact fill count and a
// one-cycle pulse for every write dropped because the FIFO was full.
module zircon_ps2_sync_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = rd_en && !empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign do_push = wr_en && (!full || do_pop);
    assign drop    = wr_en && full && !do_pop;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/zircon_avalon_ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the pins, deserialises and checks frames,
// folds E0/F0 prefixes into one event word and queues events for the Avalon slave.
module zircon_avalon_ps2_keyboard_rx_fifo
    import zircon_ps2_pkg::*;
#(
    parameter  int CLK_FREQ_HZ = 48_000_000,
    parameter  int TIMEOUT_US  = 400,
    parameter  int FIFO_DEPTH  = 16,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ps2_clk_in,
    input  logic                ps2_data_in,
    input  logic                rd_en,
    output logic [EV_WIDTH-1:0] rd_data,
    output logic                empty,
    output logic [CW-1:0]       fill_count,
    output logic                interrupt,
    input  logic                err_clr,
    output logic                parity_err,
    output logic                overflow
);

    localparam int TO_LIMIT = (CLK_FREQ_HZ / 1_000_000) * TIMEOUT_US - 1;
    localparam int TW       = (TO_LIMIT > 1) ? $clog2(TO_LIMIT + 1) : 1;

    logic                clk_meta, clk_sync, clk_prev;
    logic                data_meta, data_sync;
    logic                clk_fall, clk_edge;
    rx_state_t           state, state_next;
    logic [10:0]         shift_reg;
    logic [3:0]          bit_cnt;
    logic [TW-1:0]       to_cnt;
    logic                timeout_hit;
    logic                frame_done;
    logic                good;
    logic [7:0]          code;
    logic                ext_pend, brk_pend;
    logic                push;
    logic [EV_WIDTH-1:0] push_data;
    logic                fifo_drop;

    // Synchronisers reset to the idle-high line level so reset release makes no false edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall    = clk_prev && !clk_sync;
    assign clk_edge    = clk_prev ^ clk_sync;
    assign timeout_hit = (state == ST_SHIFT) && clk_sync && !clk_edge && (to_cnt == TW'(TO_LIMIT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            ST_IDLE:  if (clk_fall) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (clk_fall && bit_cnt == 4'd10) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                frame_done = 1'b1;
                state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Bits arrive LSB-first, so each new bit enters at the top and moves down.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            if (state == ST_IDLE || clk_edge || !clk_sync || timeout_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout_hit) begin
                bit_cnt <= '0;
            end else if (clk_fall && state == ST_IDLE) begin
                shift_reg <= {data_sync, shift_reg[10:1]};
                bit_cnt   <= 4'd1;
            end else if (clk_fall && state == ST_SHIFT) begin
                shift_reg <= {data_sync, shift_reg[10:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end else if (state == ST_CHECK) begin
                bit_cnt <= '0;
            end
        end
    end

    assign good      = frame_ok(shift_reg);
    assign code      = shift_reg[8:1];
    assign push      = frame_done && good && (code != PS2_PREFIX_EXT) && (code != PS2_PREFIX_BRK);
    assign push_data = {ext_pend, brk_pend, code};

    // Prefix flags survive a timeout abort; only a completed frame consumes or clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (frame_done) begin
                if (!good) begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end else if (code == PS2_PREFIX_EXT) begin
                    ext_pend <= 1'b1;
                end else if (code == PS2_PREFIX_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
            if (frame_done && !good) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
            if (fifo_drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    zircon_ps2_sync_fifo #(
        .WIDTH (EV_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .count   (fill_count),
        .drop    (fifo_drop)
    );

    assign interrupt = !empty;

endmodule
